// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DEPTH_DEF      = 32;
  localparam int FIFO_DEPTH     = 2;

  // Write-back source ports; the value doubles as the last-grant pointer.
  typedef enum logic {
    PORT_EX = 1'b0,
    PORT_LD = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready write-back request channel; one instance per source port.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      data;
  logic                  ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo2.sv
// Two-entry write-back FIFO. Slot 0 is always the head; both slots are
// exported so the top can derive the pending-register vector.
module wb_fifo2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       ready_o,
  output logic                       nempty_o,
  output logic [ADDR_WIDTH-1:0]      head_addr_o,
  output logic [WIDTH-1:0]           head_data_o,
  output logic [1:0]                 ent_vld_o,
  output logic [1:0][ADDR_WIDTH-1:0] ent_addr_o
);

  logic [1:0]                 count_q, count_d;
  logic [1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0][WIDTH-1:0]      data_q, data_d;
  logic                       push_ok_s, pop_ok_s;

  // Ready comes from registered occupancy only: a full FIFO never accepts,
  // even in a cycle where it is being drained.
  assign ready_o     = (count_q < 2'(FIFO_DEPTH));
  assign nempty_o    = (count_q != 2'd0);
  assign push_ok_s   = push_i && ready_o;
  assign pop_ok_s    = pop_i && nempty_o;
  assign head_addr_o = addr_q[0];
  assign head_data_o = data_q[0];
  assign ent_vld_o   = {(count_q == 2'd2), (count_q != 2'd0)};
  assign ent_addr_o  = addr_q;

  // Next-state: shift on pop, write the first free slot on push.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          addr_d[0] = addr_i;
          data_d[0] = data_i;
          count_d   = 2'd1;
        end else begin
          addr_d[1] = addr_i;
          data_d[1] = data_i;
          count_d   = 2'd2;
        end
      end
      2'b01: begin
        addr_d[0] = addr_q[1];
        data_d[0] = data_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry: the head leaves and the new entry
        // becomes the head, occupancy unchanged.
        addr_d[0] = addr_i;
        data_d[0] = data_i;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging execute and load write-backs onto the single
// register-file write port, with a per-register pending scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   ex_if,
  regfile_wb_arbiter_if.slave   ld_if,
  output logic                  we0,
  output logic [ADDR_WIDTH-1:0] wr_addr0,
  output logic [WIDTH-1:0]      wr_din0,
  output logic [DEPTH-1:0]      pending
);

  logic                       ex_ready_s, ld_ready_s, ex_ne_s, ld_ne_s;
  logic                       ex_push_s, ld_push_s, gnt_ex_s, gnt_ld_s;
  logic [ADDR_WIDTH-1:0]      ex_head_addr_s, ld_head_addr_s;
  logic [WIDTH-1:0]           ex_head_data_s, ld_head_data_s;
  logic [1:0]                 ex_vld_s, ld_vld_s;
  logic [1:0][ADDR_WIDTH-1:0] ex_ent_s, ld_ent_s;
  logic [DEPTH-1:0]           pend_s;

  port_e                      last_q, last_d;
  logic                       we0_q, we0_d;
  logic [ADDR_WIDTH-1:0]      wr_addr0_q, wr_addr0_d;
  logic [WIDTH-1:0]           wr_din0_q, wr_din0_d;

  // Writes to x0 complete the handshake but are never buffered.
  assign ex_push_s   = ex_if.valid && ex_ready_s && (ex_if.addr != {ADDR_WIDTH{1'b0}});
  assign ld_push_s   = ld_if.valid && ld_ready_s && (ld_if.addr != {ADDR_WIDTH{1'b0}});
  assign ex_if.ready = ex_ready_s;
  assign ld_if.ready = ld_ready_s;

  wb_fifo2 #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ex_fifo (
    .clk(clk), .rst(rst), .push_i(ex_push_s), .addr_i(ex_if.addr), .data_i(ex_if.data),
    .pop_i(gnt_ex_s), .ready_o(ex_ready_s), .nempty_o(ex_ne_s),
    .head_addr_o(ex_head_addr_s), .head_data_o(ex_head_data_s),
    .ent_vld_o(ex_vld_s), .ent_addr_o(ex_ent_s)
  );

  wb_fifo2 #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ld_fifo (
    .clk(clk), .rst(rst), .push_i(ld_push_s), .addr_i(ld_if.addr), .data_i(ld_if.data),
    .pop_i(gnt_ld_s), .ready_o(ld_ready_s), .nempty_o(ld_ne_s),
    .head_addr_o(ld_head_addr_s), .head_data_o(ld_head_data_s),
    .ent_vld_o(ld_vld_s), .ent_addr_o(ld_ent_s)
  );

  // Grant: the lone non-empty port, or the one not served last on contention.
  always_comb begin
    gnt_ex_s = 1'b0;
    gnt_ld_s = 1'b0;
    if (ex_ne_s && ld_ne_s) begin
      if (last_q == PORT_LD) begin
        gnt_ex_s = 1'b1;
      end else begin
        gnt_ld_s = 1'b1;
      end
    end else if (ex_ne_s) begin
      gnt_ex_s = 1'b1;
    end else if (ld_ne_s) begin
      gnt_ld_s = 1'b1;
    end else begin
      gnt_ex_s = 1'b0;
    end
  end

  // Output-register and pointer next-state; address/data hold when idle.
  always_comb begin
    last_d     = last_q;
    we0_d      = 1'b0;
    wr_addr0_d = wr_addr0_q;
    wr_din0_d  = wr_din0_q;
    if (gnt_ex_s) begin
      we0_d      = 1'b1;
      wr_addr0_d = ex_head_addr_s;
      wr_din0_d  = ex_head_data_s;
      last_d     = PORT_EX;
    end else if (gnt_ld_s) begin
      we0_d      = 1'b1;
      wr_addr0_d = ld_head_addr_s;
      wr_din0_d  = ld_head_data_s;
      last_d     = PORT_LD;
    end else begin
      we0_d = 1'b0;
    end
  end

  // Pending: any buffered entry or the in-flight output write targets reg i.
  always_comb begin
    pend_s = {DEPTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      if ((ex_vld_s[0] && (ex_ent_s[0] == ADDR_WIDTH'(i))) ||
          (ex_vld_s[1] && (ex_ent_s[1] == ADDR_WIDTH'(i))) ||
          (ld_vld_s[0] && (ld_ent_s[0] == ADDR_WIDTH'(i))) ||
          (ld_vld_s[1] && (ld_ent_s[1] == ADDR_WIDTH'(i))) ||
          (we0_q && (wr_addr0_q == ADDR_WIDTH'(i)))) begin
        pend_s[i] = 1'b1;
      end else begin
        pend_s[i] = 1'b0;
      end
    end
  end

  // Registered write port and pointer; reset lets port 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= PORT_LD;
      we0_q      <= 1'b0;
      wr_addr0_q <= {ADDR_WIDTH{1'b0}};
      wr_din0_q  <= {WIDTH{1'b0}};
    end else begin
      last_q     <= last_d;
      we0_q      <= we0_d;
      wr_addr0_q <= wr_addr0_d;
      wr_din0_q  <= wr_din0_d;
    end
  end

  assign we0      = we0_q;
  assign wr_addr0 = wr_addr0_q;
  assign wr_din0  = wr_din0_q;
  assign pending  = pend_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: queue-level reference model compared every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we0;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_din0;
  logic [31:0] pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if ex_if ();
  regfile_wb_arbiter_if ld_if ();

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .ex_if(ex_if), .ld_if(ld_if),
    .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0), .pending(pending)
  );

  int          checks = 0;
  int          errors = 0;
  int          dut_we_n = 0;
  bit          chk_en = 1'b0;
  ent_t        exq[$], ldq[$];      // model buffers
  ent_t        exs[$], lds[$];      // stimulus still to be offered
  ent_t        mlog[$];             // model commit log
  bit          m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_din = 32'd0;
  bit          m_last = 1'b1;       // 1: load port served last
  logic [31:0] pend_hist[$];
  bit          we_hist[$], ldr_hist[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] p;
    p = 32'd0;
    foreach (exq[i]) p[exq[i].a] = 1'b1;
    foreach (ldq[i]) p[ldq[i].a] = 1'b1;
    if (m_we) p[m_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic tick();
    bit   ex_acc, ld_acc, g_ex, g_ld;
    ent_t ex_e, ld_e, e;
    ex_acc = ex_if.valid && (exq.size() < 2) && (ex_if.addr != 5'd0);
    ld_acc = ld_if.valid && (ldq.size() < 2) && (ld_if.addr != 5'd0);
    ex_e = ent_t'({ex_if.addr, ex_if.data});
    ld_e = ent_t'({ld_if.addr, ld_if.data});
    @(posedge clk);
    if (rst) begin
      exq.delete(); ldq.delete();
      m_we = 1'b0; m_addr = 5'd0; m_din = 32'd0; m_last = 1'b1;
    end else begin
      g_ex = (exq.size() != 0) && ((ldq.size() == 0) || m_last);
      g_ld = (ldq.size() != 0) && !g_ex;
      if (g_ex) begin
        e = exq.pop_front(); m_we = 1'b1; m_addr = e.a; m_din = e.d; m_last = 1'b0;
      end else if (g_ld) begin
        e = ldq.pop_front(); m_we = 1'b1; m_addr = e.a; m_din = e.d; m_last = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (ex_acc) exq.push_back(ex_e);
      if (ld_acc) ldq.push_back(ld_e);
      if (m_we) mlog.push_back(ent_t'({m_addr, m_din}));
    end
  endtask

  // One cycle: offer stimulus heads, cross the edge, retire accepted items.
  task automatic cyc();
    bit exv, ldv, exr, ldr;
    exv = (exs.size() > 0) && !rst;
    ldv = (lds.size() > 0) && !rst;
    ex_if.valid = exv;
    ld_if.valid = ldv;
    ex_if.addr = exv ? exs[0].a : 5'($urandom);
    ex_if.data = exv ? exs[0].d : $urandom;
    ld_if.addr = ldv ? lds[0].a : 5'($urandom);
    ld_if.data = ldv ? lds[0].d : $urandom;
    exr = ex_if.ready;
    ldr = ld_if.ready;
    tick();
    if (rst) begin
      exs.delete(); lds.delete();
    end else begin
      if (exv && exr) exs.delete(0);
      if (ldv && ldr) lds.delete(0);
    end
    @(negedge clk);
    pend_hist.push_back(pending);
    we_hist.push_back(we0);
    ldr_hist.push_back(ld_if.ready);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mlog.delete(); pend_hist.delete(); we_hist.delete(); ldr_hist.delete();
  endtask

  task automatic chk_log(string nm, ent_t exp[$]);
    chk({nm, "_count"}, 64'(mlog.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < mlog.size()) chk(nm, 64'(mlog[i]), 64'(exp[i]));
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we0", 64'(we0), 64'(m_we));
      chk("wr_addr0", 64'(wr_addr0), 64'(m_addr));
      chk("wr_din0", 64'(wr_din0), 64'(m_din));
      chk("pending", 64'(pending), 64'(exp_pend()));
      chk("ex_ready", 64'(ex_if.ready), 64'(exq.size() < 2));
      chk("ld_ready", 64'(ld_if.ready), 64'(ldq.size() < 2));
      if (we0 === 1'b1) dut_we_n++;
    end
  end

  initial begin
    int   n0;
    logic [31:0] acc;
    ent_t exp[$];
    ex_if.valid = 1'b0; ex_if.addr = 5'd0; ex_if.data = 32'd0;
    ld_if.valid = 1'b0; ld_if.addr = 5'd0; ld_if.data = 32'd0;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("rst_we0", 64'(we0), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ex_ready", 64'(ex_if.ready), 64'd1);
    chk("rst_ld_ready", 64'(ld_if.ready), 64'd1);

    // Single write latency and pending window
    exs.push_back(ent_t'({5'd5, 32'hDEADBEEF}));
    repeat (4) cyc();
    chk("single_pend_N", 64'(pend_hist[0][5]), 64'd1);
    chk("single_we_N", 64'(we_hist[0]), 64'd0);
    chk("single_we_N1", 64'(we_hist[1]), 64'd1);
    chk("single_pend_N1", 64'(pend_hist[1][5]), 64'd1);
    chk("single_pend_N2", 64'(pend_hist[2][5]), 64'd0);
    exp = '{ent_t'({5'd5, 32'hDEADBEEF})};
    chk_log("single_log", exp);

    // Contention: alternation starting with port 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exs.push_back(ent_t'({5'(1 + i), 32'(32'h100 + i)}));
      lds.push_back(ent_t'({5'(9 + i), 32'(32'h200 + i)}));
    end
    repeat (10) cyc();
    exp = '{ent_t'({5'd1, 32'h100}), ent_t'({5'd9, 32'h200}), ent_t'({5'd2, 32'h101}),
            ent_t'({5'd10, 32'h201}), ent_t'({5'd3, 32'h102}), ent_t'({5'd11, 32'h202})};
    chk_log("contend_log", exp);

    // Backpressure on the load port
    do_reset();
    exs.push_back(ent_t'({5'd4, 32'h304}));
    exs.push_back(ent_t'({5'd6, 32'h306}));
    for (int i = 0; i < 3; i++) lds.push_back(ent_t'({5'(12 + i), 32'(32'h400 + i)}));
    repeat (10) cyc();
    chk("bp_ld_ready_full", 64'(ldr_hist[1]), 64'd0);
    chk("bp_ld_ready_after_pop", 64'(ldr_hist[2]), 64'd1);
    exp = '{ent_t'({5'd4, 32'h304}), ent_t'({5'd12, 32'h400}), ent_t'({5'd6, 32'h306}),
            ent_t'({5'd13, 32'h401}), ent_t'({5'd14, 32'h402})};
    chk_log("bp_log", exp);

    // x0 write is swallowed
    do_reset();
    n0 = dut_we_n;
    lds.push_back(ent_t'({5'd0, 32'h1234}));
    repeat (4) cyc();
    chk("x0_accepted", 64'(lds.size()), 64'd0);
    chk("x0_no_we", 64'(dut_we_n - n0), 64'd0);
    acc = 32'd0;
    foreach (pend_hist[i]) acc = acc | pend_hist[i];
    chk("x0_pending", 64'(acc), 64'd0);
    chk_log("x0_log", '{});

    // Reset while both FIFOs hold data
    do_reset();
    exs.push_back(ent_t'({5'd1, 32'h11})); exs.push_back(ent_t'({5'd2, 32'h22}));
    lds.push_back(ent_t'({5'd3, 32'h33})); lds.push_back(ent_t'({5'd4, 32'h44}));
    repeat (2) cyc();
    chk("midrst_pending_before", 64'(pending), 64'h1E);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_we0", 64'(we0), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_ex_ready", 64'(ex_if.ready), 64'd1);
    chk("midrst_ld_ready", 64'(ld_if.ready), 64'd1);
    n0 = dut_we_n;
    repeat (5) cyc();
    chk("midrst_no_stale", 64'(dut_we_n - n0), 64'd0);

    // Duplicate address ordering and pending hold
    do_reset();
    exs.push_back(ent_t'({5'd7, 32'hA}));
    exs.push_back(ent_t'({5'd7, 32'hB}));
    repeat (5) cyc();
    exp = '{ent_t'({5'd7, 32'hA}), ent_t'({5'd7, 32'hB})};
    chk_log("dup_log", exp);
    chk("dup_pend_A_commit", 64'(pend_hist[1][7]), 64'd1);
    chk("dup_pend_B_inflight", 64'(pend_hist[2][7]), 64'd1);
    chk("dup_pend_clear", 64'(pend_hist[3][7]), 64'd0);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (exs.size() == 0 && ($urandom % 4) != 0)
        exs.push_back(ent_t'({5'($urandom_range(0, 31)), 32'($urandom)}));
      if (lds.size() == 0 && ($urandom % 4) != 0)
        lds.push_back(ent_t'({5'($urandom_range(0, 31)), 32'($urandom)}));
      rst = (($urandom % 300) == 0);
      cyc();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
